// File: rtl/divider_sequencer.sv
// Iterative restoring divider sequencer for the divider2 unit: drives the divisor
// state register, runs one quotient bit per cycle and applies sign correction.
module divider_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] dividendIn,
  input  logic [WIDTH-1:0] divisorIn,
  input  logic [WIDTH-1:0] divisor,
  output logic             divisorEn,
  output logic             divisorSel,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  // Only the sign of the raw divisor matters here; the magnitude comes back via divisor.
  logic divisor_in_unused;
  assign divisor_in_unused = ^divisorIn[WIDTH-2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      raw_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      raw_q       <= raw_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    raw_d       = raw_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    divisorEn   = 1'b0;
    divisorSel  = 1'b0;
    shifted     = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    trial       = {1'b0, shifted} - {1'b0, divisor};

    unique case (state_q)
      S_IDLE: begin
        if (start && !reset) begin
          divisorEn  = 1'b1;
          divisorSel = isSigned & divisorIn[WIDTH-1];
          rem_d      = '0;
          quo_d      = (isSigned & dividendIn[WIDTH-1]) ? WIDTH'(-dividendIn) : dividendIn;
          neg_q_d    = isSigned & (dividendIn[WIDTH-1] ^ divisorIn[WIDTH-1]);
          neg_r_d    = isSigned & dividendIn[WIDTH-1];
          raw_d      = dividendIn;
          dbz_d      = 1'b0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (divisor == '0) begin
          quotient_d  = '1;
          remainder_d = raw_q;
          dbz_d       = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        // Restore on borrow: keep the shifted partial remainder and shift in a 0.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quotient_d  = neg_q_q ? WIDTH'(-quo_q) : quo_q;
        remainder_d = neg_r_q ? WIDTH'(-rem_q) : rem_q;
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign divByZero = dbz_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_divider_sequencer.sv
// Scoreboard bench for divider_sequencer: models the divisor state register and
// checks results against a plain-arithmetic division reference.
module tb_divider_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        isSigned = 1'b0;
  logic [31:0] dividendIn = '0;
  logic [31:0] divisorIn = '0;
  logic [31:0] div_reg;
  logic        divisorEn, divisorSel, busy, done, divByZero;
  logic [31:0] quotient, remainder;

  int          tests = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  exp_t mon_e;

  divider_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .isSigned(isSigned),
    .dividendIn(dividendIn), .divisorIn(divisorIn), .divisor(div_reg),
    .divisorEn(divisorEn), .divisorSel(divisorSel), .busy(busy), .done(done),
    .divByZero(divByZero), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: the divisor state register loads the raw or negated divisor.
  always @(posedge clk) begin
    if (reset) div_reg <= '0;
    else if (divisorEn) div_reg <= divisorSel ? -divisorIn : divisorIn;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned ma, mb, q, r;
    logic na, nb;
    na = s & a[31];
    nb = s & b[31];
    ma = na ? (64'h1_0000_0000 - 64'(a)) : 64'(a);
    mb = nb ? (64'h1_0000_0000 - 64'(b)) : 64'(b);
    e.at = 0;
    if (mb == 0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      q = ma / mb;
      r = ma % mb;
      if (na ^ nb) q = 64'h1_0000_0000 - q;
      if (na) r = 64'h1_0000_0000 - r;
      e.q = 32'(q);
      e.r = 32'(r);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy === 1'b1) chk("den_while_busy", {31'b0, divisorEn}, 32'd0);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("quotient", quotient, mon_e.q);
          chk("remainder", remainder, mon_e.r);
          chk("divByZero", {31'b0, divByZero}, {31'b0, mon_e.dbz});
          chk("done_cycle", cyc, mon_e.at);
          last = mon_e;
        end
      end
    end
  end

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int unsigned t);
    exp_t e;
    @(posedge clk);
    #1;
    isSigned = s;
    dividendIn = a;
    divisorIn = b;
    start = 1'b1;
    t = cyc;
    e = model(s, a, b);
    e.at = t + (e.dbz ? 2 : 35);
    sb.push_back(e);
    @(negedge clk);
    chk("divisorEn_at_T", {31'b0, divisorEn}, 32'd1);
    chk("divisorSel_at_T", {31'b0, divisorSel}, {31'b0, s & b[31]});
    @(posedge clk);
    #1;
    start = 1'b0;
    dividendIn = $urandom;
    divisorIn = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      tests++;
      errors++;
      $display("FAIL wait_idle: got busy=%0b pending=%0d after 60 cycles, required idle", busy, sb.size());
    end
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    int unsigned t;
    launch(s, a, b, t);
    wait_idle();
  endtask

  task automatic goto(input int unsigned c);
    while (cyc != c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    isSigned = 1'($urandom_range(0, 1));
    dividendIn = $urandom;
    divisorIn = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = 32'($urandom_range(0, 20));
      1: v = $urandom;
      2: v = -32'($urandom_range(1, 20));
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned t;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dbz", {31'b0, divByZero}, 32'd0);
    chk("rst_den", {31'b0, divisorEn}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);

    run_op(1'b0, 32'd100, 32'd7);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9);
    run_op(1'b0, 32'h1234_5678, 32'd0);
    repeat (2) @(negedge clk);
    chk("dbz_hold", {31'b0, divByZero}, 32'd1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    repeat (3) @(negedge clk);
    chk("hold_quotient", quotient, last.q);
    chk("hold_remainder", remainder, last.r);
    chk("dbz_cleared", {31'b0, divByZero}, 32'd0);

    // Starts while busy and in the DONE cycle must be ignored.
    launch(1'b0, 32'd100, 32'd7, t);
    goto(t + 5);
    pulse_start();
    goto(t + 20);
    pulse_start();
    goto(t + 35);
    pulse_start();
    @(negedge clk);
    chk("start_in_done_ignored", {31'b0, busy}, 32'd0);
    wait_idle();

    // Reset mid-operation abandons it with no done.
    launch(1'b1, $urandom, rand_operand(), t);
    goto(t + 10);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    repeat (40) @(negedge clk);
    run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom_range(0, 1)), rand_operand(), rand_operand());
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
